// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                         |
// | Description : Shares one single-ported memory between instruction     |
// |               fetch and M-stage data access. Data goes first, the     |
// |               pipeline stalls until both accesses of the slot are     |
// |               done. Also builds store byte lanes, drops misaligned    |
// |               data accesses and runs a request watchdog.              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   output logic [31:0] InstrF,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        stall,
   output logic        misalign,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        d_done;
   logic        f_done;
   logic [31:0] instr_buf;
   logic [31:0] rdata_buf;
   logic [7:0]  wait_cnt;

   logic        d_req;
   logic        d_pending;
   logic        mis_addr;
   logic        sel_data;
   logic        sel_fetch;
   logic        data_ack;
   logic        fetch_ack;
   logic        d_done_now;
   logic        f_done_now;
   logic [3:0]  store_be;
   logic [31:0] store_wdata;
   logic        unused_ok;

   assign d_req     = MemReadM | MemWriteM;
   assign d_pending = d_req & ~d_done;

   // Misaligned: half on odd address, word (or wider) off a word boundary.
   always_comb begin
      mis_addr = 1'b0;
      case (funct3M[1:0])
         2'b01:        mis_addr = ALUResultM[0];
         2'b10, 2'b11: mis_addr = |ALUResultM[1:0];
         default:      mis_addr = 1'b0;
      endcase
   end

   // Store lane steering: replicate the LSB-aligned data and enable the addressed bytes.
   always_comb begin
      store_be    = 4'b1111;
      store_wdata = WriteDataM;
      case (funct3M[1:0])
         2'b00: begin
            store_be    = 4'b0001 << ALUResultM[1:0];
            store_wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            store_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            store_wdata = {2{WriteDataM[15:0]}};
         end
         default: begin
            store_be    = 4'b1111;
            store_wdata = WriteDataM;
         end
      endcase
   end

   // Arbitration: choose the access driven this cycle, detect completion, pick next state.
   always_comb begin
      state_next = state;
      sel_data   = 1'b0;
      sel_fetch  = 1'b0;
      misalign   = 1'b0;
      case (state)
         IDLE: begin
            if (d_pending && !mis_addr) begin
               sel_data = 1'b1;
            end else begin
               // A pending data access reaching here is misaligned: drop it, let fetch go.
               misalign  = d_pending;
               sel_fetch = ~f_done;
            end
         end
         DATA:    sel_data  = 1'b1;
         FETCH:   sel_fetch = 1'b1;
         default: sel_data  = 1'b0;
      endcase
      // Reset removes any request at once, independent of the clock.
      if (!reset) begin
         sel_data  = 1'b0;
         sel_fetch = 1'b0;
         misalign  = 1'b0;
      end
      data_ack   = sel_data & mem_ack;
      fetch_ack  = sel_fetch & mem_ack;
      d_done_now = d_done | data_ack | misalign;
      f_done_now = f_done | fetch_ack;
      case (state)
         IDLE: begin
            // Ack in the issue cycle completes the access without leaving IDLE.
            if (sel_data && !data_ack) begin
               state_next = DATA;
            end else if (sel_fetch && !fetch_ack) begin
               state_next = FETCH;
            end
         end
         DATA:    if (data_ack) state_next = f_done ? IDLE : FETCH;
         FETCH:   if (fetch_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory port drive for whichever access is selected.
   always_comb begin
      mem_req   = sel_data | sel_fetch;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_be    = 4'b0000;
      mem_wdata = 32'd0;
      if (sel_data) begin
         mem_addr  = {ALUResultM[31:2], 2'b00};
         mem_we    = MemWriteM;
         mem_be    = MemWriteM ? store_be : 4'b1111;
         mem_wdata = MemWriteM ? store_wdata : 32'd0;
      end else if (sel_fetch) begin
         mem_addr = {PCF[31:2], 2'b00};
         mem_be   = 4'b1111;
      end
   end

   assign stall     = ~reset | (d_req & ~d_done_now) | ~f_done_now;
   assign InstrF    = fetch_ack ? mem_rdata : instr_buf;
   assign ReadDataM = data_ack ? mem_rdata : (misalign ? 32'd0 : rdata_buf);
   assign unused_ok = &{1'b0, funct3M[2], PCF[1:0]};

   // State, per-slot completion flags and result buffers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         d_done    <= 1'b0;
         f_done    <= 1'b0;
         instr_buf <= 32'd0;
         rdata_buf <= 32'd0;
      end else begin
         state  <= state_next;
         d_done <= stall ? d_done_now : 1'b0;
         f_done <= stall ? f_done_now : 1'b0;
         if (data_ack) begin
            rdata_buf <= mem_rdata;
         end else if (misalign) begin
            rdata_buf <= 32'd0;
         end
         if (fetch_ack) begin
            instr_buf <= mem_rdata;
         end
      end
   end

   // Watchdog: count unacknowledged request cycles; err is sticky until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= 8'd0;
         err      <= 1'b0;
      end else if (mem_req && !mem_ack) begin
         if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (wait_cnt + 8'd1 == WAIT_LIMIT) begin
            err <= 1'b1;
         end
      end else begin
         wait_cnt <= 8'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                      |
// | Description : Self-checking bench for mem_port_arbiter with a slot-   |
// |               level reference model and a wait-state memory model.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] PCF;
   logic [31:0] InstrF;
   logic        MemReadM;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        stall;
   logic        misalign;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem     [0:255];   // storage behind the memory port
   logic [31:0] ref_mem [0:255];   // reference view of memory contents

   int          obs_stall_cnt;
   int          obs_mis_cnt;
   int          obs_dreq_cnt;
   logic [3:0]  obs_be0;
   logic [31:0] obs_wd0;
   logic [31:0] obs_addr0;
   logic        obs_we0;
   logic        obs_stall0;
   logic [31:0] obs_instr;
   logic [31:0] obs_rdata;

   mem_port_arbiter #(.MAX_WAIT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .PCF        (PCF),
      .InstrF     (InstrF),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .stall      (stall),
      .misalign   (misalign),
      .err        (err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Per-cycle comparison of DUT outputs against the slot model.
   task automatic compare_cycle(input logic last, input logic exp_mis,
                                input logic [31:0] ea, input logic ewe, input logic [3:0] ebe,
                                input logic [31:0] ewd, input logic chkwd, input logic chkrd,
                                input logic [31:0] ei, input logic [31:0] er);
      check1("stall", stall, !last);
      check1("mem_req", mem_req, 1'b1);
      check32("mem_addr", mem_addr, ea);
      check1("mem_we", mem_we, ewe);
      check32("mem_be", {28'd0, mem_be}, {28'd0, ebe});
      if (chkwd) check32("mem_wdata", mem_wdata, ewd);
      check1("misalign", misalign, exp_mis);
      check1("err", err, 1'b0);
      if (last) begin
         check32("InstrF", InstrF, ei);
         if (chkrd) check32("ReadDataM", ReadDataM, er);
      end
   endtask

   // One pipeline slot: model the expected request sequence, act as memory, compare each cycle.
   task automatic run_slot(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                           input int d_wait, input int f_wait);
      logic [31:0] ra  [2];
      logic        rwe [2];
      logic [3:0]  rbe [2];
      logic [31:0] rwd [2];
      logic        rchk[2];
      int          rw  [2];
      logic        mis;
      logic [31:0] e_instr;
      logic [31:0] e_rdata;
      int n, nb, off, total, j, el;

      nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off   = int'(alu[1:0]);
      mis   = (rd | wr) && ((off % nb) != 0);
      n     = 0;
      if ((rd | wr) && !mis) begin
         ra[0]   = {alu[31:2], 2'b00};
         rwe[0]  = wr;
         rchk[0] = wr;
         rw[0]   = d_wait;
         for (int b = 0; b < 4; b++) begin
            rbe[0][b]       = wr ? (b >= off && b < off + nb) : 1'b1;
            rwd[0][8*b +: 8] = wd[8*(b % nb) +: 8];
         end
         n = 1;
      end
      ra[n]   = {pc[31:2], 2'b00};
      rwe[n]  = 1'b0;
      rbe[n]  = 4'hF;
      rwd[n]  = 32'd0;
      rchk[n] = 1'b0;
      rw[n]   = f_wait;
      n++;

      e_rdata = mis ? 32'd0 : ref_mem[alu[9:2]];
      if (wr && !mis) begin
         for (int b = off; b < off + nb; b++) begin
            ref_mem[alu[9:2]][8*b +: 8] = wd[8*(b - off) +: 8];
         end
      end
      e_instr = ref_mem[pc[9:2]];
      total = 0;
      for (int i = 0; i < n; i++) total += rw[i] + 1;

      MemReadM   = rd;
      MemWriteM  = wr;
      funct3M    = f3;
      ALUResultM = alu;
      WriteDataM = wd;
      PCF        = pc;
      obs_stall_cnt = 0;
      obs_mis_cnt   = 0;
      obs_dreq_cnt  = 0;
      j  = 0;
      el = 0;
      for (int k = 0; k < total; k++) begin
         #1;
         mem_ack   = mem_req && (el == rw[j]);
         mem_rdata = mem[mem_addr[9:2]];
         if (mem_ack && mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
         end
         @(negedge clk);
         compare_cycle(k == total - 1, mis && (k == 0), ra[j], rwe[j], rbe[j], rwd[j],
                       rchk[j], rd, e_instr, e_rdata);
         if (k == 0) begin
            obs_be0    = mem_be;
            obs_wd0    = mem_wdata;
            obs_we0    = mem_we;
            obs_stall0 = stall;
            obs_addr0  = mem_addr;
         end
         if (stall) obs_stall_cnt++;
         if (misalign) obs_mis_cnt++;
         if (mem_req && mem_addr != {pc[31:2], 2'b00}) obs_dreq_cnt++;
         if (k == total - 1) begin
            obs_instr = InstrF;
            obs_rdata = ReadDataM;
         end
         if (el == rw[j]) begin
            j++;
            el = 0;
         end else begin
            el++;
         end
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] r_alu, r_wd, r_pc;
      logic [2:0]  r_f3;
      int          kind;

      reset      = 1'b0;
      PCF        = 32'd0;
      MemReadM   = 1'b0;
      MemWriteM  = 1'b0;
      funct3M    = 3'd0;
      ALUResultM = 32'd0;
      WriteDataM = 32'd0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'd0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[0]   = 32'h0000_0093; ref_mem[0]   = 32'h0000_0093;
      mem[1]   = 32'h0010_0113; ref_mem[1]   = 32'h0010_0113;
      mem[2]   = 32'h0020_0193; ref_mem[2]   = 32'h0020_0193;
      mem[4]   = 32'h0040_0213; ref_mem[4]   = 32'h0040_0213;
      mem[128] = 32'hDEAD_BEEF; ref_mem[128] = 32'hDEAD_BEEF;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check1("rst_stall", stall, 1'b1);
      check1("rst_mem_req", mem_req, 1'b0);
      check1("rst_mem_we", mem_we, 1'b0);
      check32("rst_mem_be", {28'd0, mem_be}, 32'd0);
      check1("rst_misalign", misalign, 1'b0);
      check1("rst_err", err, 1'b0);
      reset = 1'b1;

      // Zero-wait fetch-only slots.
      run_slot(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h00, 0, 0);
      check32("f0_stalls", 32'(obs_stall_cnt), 32'd0);
      check32("f0_instr", obs_instr, 32'h0000_0093);
      run_slot(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h04, 0, 0);
      check32("f4_instr", obs_instr, 32'h0010_0113);
      run_slot(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h08, 0, 0);
      check32("f8_instr", obs_instr, 32'h0020_0193);
      check32("f8_stalls", 32'(obs_stall_cnt), 32'd0);

      // Zero-wait byte store to 0x103.
      run_slot(1'b0, 1'b1, 3'b000, 32'h103, 32'hAB, 32'h0C, 0, 0);
      check32("sb_be", {28'd0, obs_be0}, 32'h8);
      check32("sb_wdata", obs_wd0, 32'hABAB_ABAB);
      check1("sb_we", obs_we0, 1'b1);
      check1("sb_stall0", obs_stall0, 1'b1);
      check32("sb_stalls", 32'(obs_stall_cnt), 32'd1);

      // Two-wait word load from 0x200.
      run_slot(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 32'h10, 2, 2);
      check32("lw_stalls", 32'(obs_stall_cnt), 32'd5);
      check32("lw_rdata", obs_rdata, 32'hDEAD_BEEF);
      check32("lw_instr", obs_instr, 32'h0040_0213);

      // Misaligned word load at 0x202.
      run_slot(1'b1, 1'b0, 3'b010, 32'h202, 32'd0, 32'h14, 0, 1);
      check32("mis_pulses", 32'(obs_mis_cnt), 32'd1);
      check32("mis_rdata", obs_rdata, 32'd0);
      check32("mis_data_reqs", 32'(obs_dreq_cnt), 32'd0);
      check32("mis_stalls", 32'(obs_stall_cnt), 32'd1);

      // Randomized slots.
      for (int s = 0; s < 200; s++) begin
         kind  = int'($urandom_range(0, 3));
         r_f3  = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
         r_alu = 32'($urandom_range(0, 1023));
         r_wd  = $urandom;
         r_pc  = 32'($urandom_range(0, 255)) << 2;
         run_slot(kind == 1 || kind == 3, kind == 2, r_f3, r_alu, r_wd, r_pc,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      // Memory that never acknowledges: watchdog with MAX_WAIT = 4.
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      PCF       = 32'h40;
      for (int k = 0; k < 8; k++) begin
         #1;
         mem_ack = 1'b0;
         @(negedge clk);
         check1("wd_req", mem_req, 1'b1);
         check32("wd_addr", mem_addr, 32'h40);
         check1("wd_stall", stall, 1'b1);
         check1("wd_err", err, k >= 4);
         @(posedge clk);
         #1;
      end
      #1;
      reset = 1'b0;
      #1;
      check1("wdrst_req", mem_req, 1'b0);
      check1("wdrst_err", err, 1'b0);
      check1("wdrst_stall", stall, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset asserted while a 3-wait load is in DATA.
      MemReadM   = 1'b1;
      funct3M    = 3'b010;
      ALUResultM = 32'h300;
      PCF        = 32'h50;
      #1;
      mem_ack = 1'b0;
      @(negedge clk);
      check32("md_addr", mem_addr, 32'h300);
      @(posedge clk);
      #1;
      #1;
      check1("md_req_before", mem_req, 1'b1);
      reset = 1'b0;
      #1;
      check1("md_req_drop", mem_req, 1'b0);
      check1("md_stall", stall, 1'b1);
      check1("md_err", err, 1'b0);
      check32("md_be", {28'd0, mem_be}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      run_slot(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h50, 0, 1);
      check32("post_rst_addr", obs_addr0, 32'h50);
      check1("post_rst_we", obs_we0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
